scan_monitor: RTL and testbench
===============================

SCAN_MONITOR -- requirements
Module: scan_monitor

Interface
REQ-001 Parameter WIDTH, default 10, number of LEDs in the scanner bar.
REQ-002 Parameter IDX_W, default 4, width of index outputs; SHALL satisfy 2^IDX_W >= WIDTH.
REQ-003 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 step  input  1  one-cycle strobe: bar_in carries a new scanner pattern this cycle.
REQ-006 bar_in  input  WIDTH  observed LED bar pattern, expected one-hot.
REQ-007 position  output  IDX_W  index of the last accepted one-hot bit.
REQ-008 direction  output  1  direction of the last accepted move; 1 = toward higher index, 0 = toward lower.
REQ-009 locked  output  1  high while the monitor is tracking a legal scan sequence.
REQ-010 error  output  1  one-cycle pulse on each rejected step.
REQ-011 sweep_count  output  8  reversals observed while tracking; wraps modulo 256.
REQ-012 error_count  output  8  rejected steps; saturates at 255.

Function
REQ-013 The block SHALL decode bar_in as legal only when exactly one bit is set; all-zero and multi-bit patterns SHALL be illegal.
REQ-014 When step is low, bar_in SHALL be ignored and all outputs SHALL hold, except error, which SHALL be 0.
REQ-015 All outputs SHALL be registered and SHALL reflect a step on the cycle after it is sampled.
REQ-016 The FSM SHALL have exactly three states: ACQUIRE, DIRECT and TRACK.
REQ-017 ACQUIRE, legal step: SHALL store the index in position, then move to DIRECT.
REQ-018 ACQUIRE, illegal step: SHALL pulse error, increment error_count and stay in ACQUIRE.
REQ-019 DIRECT, legal step with index = position+1: SHALL set direction=1, update position, set locked=1 and move to TRACK.
REQ-020 DIRECT, legal step with index = position-1: SHALL set direction=0, update position, set locked=1 and move to TRACK.
REQ-021 DIRECT, any other legal index: SHALL pulse error, increment error_count, update position and stay in DIRECT.
REQ-022 DIRECT, illegal step: SHALL pulse error, increment error_count, hold position and move to ACQUIRE.
REQ-023 TRACK expected index, direction=1: position+1 if position < WIDTH-1, else WIDTH-2.
REQ-024 TRACK expected index, direction=0: position-1 if position > 0, else 1.
REQ-025 TRACK, legal step matching the expected index: SHALL update position and set direction to the sign of the move.
REQ-026 In that case, if direction changes, sweep_count SHALL increment by 1, wrapping 255 to 0.
REQ-027 TRACK, legal mismatch (including a repeated index): SHALL pulse error, increment error_count, clear locked, update position and move to DIRECT.
REQ-028 TRACK, illegal step: SHALL pulse error, increment error_count, clear locked, hold position and move to ACQUIRE.
REQ-029 locked SHALL be 1 only in TRACK.
REQ-030 error_count SHALL hold at 255 on further errors; error SHALL still pulse.
REQ-031 Index arithmetic SHALL be IDX_W bits wide; no expected index outside 0..WIDTH-1 SHALL be generated.

Reset
REQ-032 reset SHALL take priority over step.
REQ-033 On reset the block SHALL enter ACQUIRE and set position=0, direction=1, locked=0, error=0, sweep_count=0 and error_count=0.
REQ-034 Reset asserted mid-operation SHALL discard tracking history; the next legal step SHALL be treated as a first sample.

Verification
REQ-035 Reset, then steps 0x001, 0x002, 0x004 -> after the third step: locked=1, position=2, direction=1, error_count=0.
REQ-036 From lock, steps walking index 3..9..0..1 -> no error pulses; sweep_count=2; direction=1 after the final step.
REQ-037 Tracking up at index 3, then step 0x020 (index 5) -> one-cycle error, error_count=1, locked=0, position=5, state DIRECT.
REQ-038 Tracking, then step 0x003 -> error pulse, locked=0, position held, state ACQUIRE; the next two adjacent legal steps relock.
REQ-039 260 consecutive steps of 0x000 -> error pulses on every step; error_count=255.
REQ-040 reset and step high in the same cycle while tracking -> all outputs at their reset values the next cycle; that step is ignored.

Source files
------------

// File: rtl/scan_monitor.sv
// rtl/scan_monitor.sv - LED scanner bar monitor tracking a one-hot bounce sequence
module scan_monitor #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             step,
    input  logic [WIDTH-1:0] bar_in,
    output logic [IDX_W-1:0] position,
    output logic             direction,
    output logic             locked,
    output logic             error,
    output logic [7:0]       sweep_count,
    output logic [7:0]       error_count
);

    typedef enum logic [1:0] {ACQUIRE, DIRECT, TRACK} state_t;

    localparam logic [IDX_W-1:0] IDX_ZERO   = '0;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(WIDTH - 2);

    state_t           state;
    logic             legal;
    logic [IDX_W-1:0] bar_idx;
    logic [IDX_W-1:0] pos_inc;
    logic [IDX_W-1:0] pos_dec;
    logic [IDX_W-1:0] expected;
    logic             is_up;
    logic             is_down;
    logic             move_up;
    logic [7:0]       err_next;

    always_comb begin
        legal   = (bar_in != '0) && ((bar_in & (bar_in - WIDTH'(1))) == '0);
        bar_idx = IDX_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            if (bar_in[i]) begin
                bar_idx = IDX_W'(i);
            end
        end
    end

    // Neighbour arithmetic is guarded at the bar ends so no index outside the bar is produced
    always_comb begin
        pos_inc  = position + IDX_ONE;
        pos_dec  = position - IDX_ONE;
        is_up    = (position != IDX_LAST) && (bar_idx == pos_inc);
        is_down  = (position != IDX_ZERO) && (bar_idx == pos_dec);
        move_up  = bar_idx > position;
        if (direction) begin
            expected = (position < IDX_LAST) ? pos_inc : IDX_PENULT;
        end else begin
            expected = (position > IDX_ZERO) ? pos_dec : IDX_ONE;
        end
        err_next = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= ACQUIRE;
            position    <= IDX_ZERO;
            direction   <= 1'b1;
            locked      <= 1'b0;
            error       <= 1'b0;
            sweep_count <= 8'd0;
            error_count <= 8'd0;
        end else begin
            error <= 1'b0;
            if (step) begin
                case (state)
                    ACQUIRE: begin
                        if (legal) begin
                            position <= bar_idx;
                            state    <= DIRECT;
                        end else begin
                            error       <= 1'b1;
                            error_count <= err_next;
                        end
                    end
                    DIRECT: begin
                        if (!legal) begin
                            error       <= 1'b1;
                            error_count <= err_next;
                            state       <= ACQUIRE;
                        end else if (is_up || is_down) begin
                            direction <= is_up;
                            position  <= bar_idx;
                            locked    <= 1'b1;
                            state     <= TRACK;
                        end else begin
                            error       <= 1'b1;
                            error_count <= err_next;
                            position    <= bar_idx;
                        end
                    end
                    TRACK: begin
                        if (!legal) begin
                            error       <= 1'b1;
                            error_count <= err_next;
                            locked      <= 1'b0;
                            state       <= ACQUIRE;
                        end else if (bar_idx == expected) begin
                            position  <= bar_idx;
                            direction <= move_up;
                            if (move_up != direction) begin
                                sweep_count <= sweep_count + 8'd1;
                            end
                        end else begin
                            error       <= 1'b1;
                            error_count <= err_next;
                            locked      <= 1'b0;
                            position    <= bar_idx;
                            state       <= DIRECT;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                        state  <= ACQUIRE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_monitor.sv
// tb/tb_scan_monitor.sv - directed self-checking bench for scan_monitor
module tb_scan_monitor;

    logic       CLOCK_50;
    logic       reset;
    logic       step;
    logic [9:0] bar_in;
    logic [3:0] position;
    logic       direction;
    logic       locked;
    logic       error;
    logic [7:0] sweep_count;
    logic [7:0] error_count;

    int vectors;
    int miscompares;

    scan_monitor #(.WIDTH(10), .IDX_W(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .step        (step),
        .bar_in      (bar_in),
        .position    (position),
        .direction   (direction),
        .locked      (locked),
        .error       (error),
        .sweep_count (sweep_count),
        .error_count (error_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one strobe between falling edges; outputs are sampled on the following falling edge
    task automatic apply(input logic [9:0] pat);
        @(negedge CLOCK_50);
        step   = 1'b1;
        bar_in = pat;
        @(negedge CLOCK_50);
        step   = 1'b0;
        bar_in = 10'h000;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        step        = 1'b0;
        bar_in      = 10'h000;

        do_reset();
        chk("rst_position", 32'(position), 32'd0);
        chk("rst_direction", 32'(direction), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_sweep", 32'(sweep_count), 32'd0);
        chk("rst_errcnt", 32'(error_count), 32'd0);

        apply(10'h001);
        chk("acq_locked", 32'(locked), 32'd0);
        apply(10'h002);
        chk("dir_locked", 32'(locked), 32'd1);
        apply(10'h004);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_position", 32'(position), 32'd2);
        chk("lock_direction", 32'(direction), 32'd1);
        chk("lock_errcnt", 32'(error_count), 32'd0);
        chk("lock_error", 32'(error), 32'd0);

        for (int i = 3; i <= 9; i++) begin
            pat = 10'd1 << i;
            apply(pat);
            chk("walk_up_error", 32'(error), 32'd0);
        end
        chk("top_sweep", 32'(sweep_count), 32'd0);
        for (int i = 8; i >= 0; i--) begin
            pat = 10'd1 << i;
            apply(pat);
            chk("walk_dn_error", 32'(error), 32'd0);
        end
        chk("bottom_direction", 32'(direction), 32'd0);
        apply(10'h002);
        chk("walk_end_error", 32'(error), 32'd0);
        chk("walk_sweep", 32'(sweep_count), 32'd2);
        chk("walk_direction", 32'(direction), 32'd1);
        chk("walk_position", 32'(position), 32'd1);
        chk("walk_locked", 32'(locked), 32'd1);

        apply(10'h004);
        apply(10'h008);
        chk("at3_position", 32'(position), 32'd3);
        apply(10'h020);
        chk("skip_error", 32'(error), 32'd1);
        chk("skip_errcnt", 32'(error_count), 32'd1);
        chk("skip_locked", 32'(locked), 32'd0);
        chk("skip_position", 32'(position), 32'd5);
        @(negedge CLOCK_50);
        chk("skip_error_1cyc", 32'(error), 32'd0);
        apply(10'h040);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_error", 32'(error), 32'd0);
        chk("relock_direction", 32'(direction), 32'd1);

        apply(10'h003);
        chk("multi_error", 32'(error), 32'd1);
        chk("multi_locked", 32'(locked), 32'd0);
        chk("multi_position", 32'(position), 32'd6);
        chk("multi_errcnt", 32'(error_count), 32'd2);
        apply(10'h100);
        chk("acq2_error", 32'(error), 32'd0);
        chk("acq2_position", 32'(position), 32'd8);
        chk("acq2_locked", 32'(locked), 32'd0);
        apply(10'h080);
        chk("acq2_relock", 32'(locked), 32'd1);
        chk("acq2_direction", 32'(direction), 32'd0);
        chk("acq2_sweep", 32'(sweep_count), 32'd2);

        apply(10'h080);
        chk("repeat_error", 32'(error), 32'd1);
        chk("repeat_locked", 32'(locked), 32'd0);
        chk("repeat_errcnt", 32'(error_count), 32'd3);
        apply(10'h100);
        chk("repeat_relock", 32'(locked), 32'd1);
        chk("repeat_direction", 32'(direction), 32'd1);

        @(negedge CLOCK_50);
        bar_in = 10'h3FF;
        repeat (3) @(negedge CLOCK_50);
        chk("hold_position", 32'(position), 32'd8);
        chk("hold_error", 32'(error), 32'd0);
        chk("hold_errcnt", 32'(error_count), 32'd3);
        chk("hold_locked", 32'(locked), 32'd1);
        bar_in = 10'h000;

        @(negedge CLOCK_50);
        reset  = 1'b1;
        step   = 1'b1;
        bar_in = 10'h200;
        @(negedge CLOCK_50);
        reset  = 1'b0;
        step   = 1'b0;
        bar_in = 10'h000;
        chk("rs_position", 32'(position), 32'd0);
        chk("rs_direction", 32'(direction), 32'd1);
        chk("rs_locked", 32'(locked), 32'd0);
        chk("rs_error", 32'(error), 32'd0);
        chk("rs_sweep", 32'(sweep_count), 32'd0);
        chk("rs_errcnt", 32'(error_count), 32'd0);
        apply(10'h200);
        chk("post_rst_error", 32'(error), 32'd0);
        chk("post_rst_position", 32'(position), 32'd9);
        chk("post_rst_locked", 32'(locked), 32'd0);

        do_reset();
        for (int i = 0; i < 260; i++) begin
            apply(10'h000);
            chk("zero_error", 32'(error), 32'd1);
        end
        chk("sat_errcnt", 32'(error_count), 32'd255);
        chk("sat_locked", 32'(locked), 32'd0);
        chk("sat_position", 32'(position), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
